// File: rtl/snoop_port_arbiter.sv
// Round-robin arbiter sharing one cache ACE snoop port (AC/CR/CD) between NumReq
// snoop sources; one complete snoop transaction is served at a time.
module snoop_port_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  // source side
  input  logic [NumReq-1:0]                    req_ac_valid_i,
  output logic [NumReq-1:0]                    req_ac_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]     req_ac_addr_i,
  input  logic [NumReq-1:0][3:0]               req_ac_snoop_i,
  input  logic [NumReq-1:0][2:0]               req_ac_prot_i,
  output logic [NumReq-1:0]                    req_cr_valid_o,
  input  logic [NumReq-1:0]                    req_cr_ready_i,
  output logic [4:0]                           req_cr_resp_o,
  output logic [NumReq-1:0]                    req_cd_valid_o,
  input  logic [NumReq-1:0]                    req_cd_ready_i,
  output logic [DataWidth-1:0]                 req_cd_data_o,
  output logic                                 req_cd_last_o,
  // cache side
  output logic                                 ac_valid_o,
  input  logic                                 ac_ready_i,
  output logic [AddrWidth-1:0]                 ac_addr_o,
  output logic [3:0]                           ac_snoop_o,
  output logic [2:0]                           ac_prot_o,
  input  logic                                 cr_valid_i,
  output logic                                 cr_ready_o,
  input  logic [4:0]                           cr_resp_i,
  input  logic                                 cd_valid_i,
  output logic                                 cd_ready_o,
  input  logic [DataWidth-1:0]                 cd_data_i,
  input  logic                                 cd_last_i,
  // status
  output logic                                 busy_o,
  output logic [IdxWidth-1:0]                  owner_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AC,
    ST_CR,
    ST_CD
  } state_e;

  state_e                state_q;
  logic [IdxWidth-1:0]   owner_q;
  logic [IdxWidth-1:0]   last_q;
  logic [AddrWidth-1:0]  addr_q;
  logic [3:0]            snoop_q;
  logic [2:0]            prot_q;
  logic                  ac_valid_q;
  logic                  busy_q;

  logic [IdxWidth-1:0]   winner;
  logic [IdxWidth-1:0]   cand;
  logic                  grant_valid;
  logic                  accept;

  // Cyclic search starting right after the last served source, so that source
  // ends up with the lowest priority.
  always_comb begin
    winner      = '0;
    cand        = '0;
    grant_valid = 1'b0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand = IdxWidth'((32'(last_q) + i) % NumReq);
      if (!grant_valid && req_ac_valid_i[cand]) begin
        grant_valid = 1'b1;
        winner      = cand;
      end
    end
  end

  assign accept = (state_q == ST_IDLE) && grant_valid && !rst_i;

  always_comb begin
    req_ac_ready_o = '0;
    if (accept) begin
      req_ac_ready_o[winner] = 1'b1;
    end
  end

  // CR/CD are steered to the owner only; everything is quiet outside CR/CD.
  always_comb begin
    req_cr_valid_o = '0;
    cr_ready_o     = 1'b0;
    req_cr_resp_o  = '0;
    req_cd_valid_o = '0;
    cd_ready_o     = 1'b0;
    req_cd_data_o  = '0;
    req_cd_last_o  = 1'b0;
    if (state_q == ST_CR) begin
      req_cr_valid_o[owner_q] = cr_valid_i;
      cr_ready_o              = req_cr_ready_i[owner_q];
      req_cr_resp_o           = cr_resp_i;
    end
    if (state_q == ST_CD) begin
      req_cd_valid_o[owner_q] = cd_valid_i;
      cd_ready_o              = req_cd_ready_i[owner_q];
      req_cd_data_o           = cd_data_i;
      req_cd_last_o           = cd_last_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      last_q     <= IdxWidth'(NumReq - 1);
      addr_q     <= '0;
      snoop_q    <= '0;
      prot_q     <= '0;
      ac_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q     <= req_ac_addr_i[winner];
            snoop_q    <= req_ac_snoop_i[winner];
            prot_q     <= req_ac_prot_i[winner];
            owner_q    <= winner;
            last_q     <= winner;
            ac_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_AC;
          end
        end
        ST_AC: begin
          if (ac_ready_i) begin
            ac_valid_q <= 1'b0;
            state_q    <= ST_CR;
          end
        end
        ST_CR: begin
          if (cr_valid_i && cr_ready_o) begin
            if (cr_resp_i[0]) begin
              state_q <= ST_CD;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_CD: begin
          if (cd_valid_i && cd_ready_o && cd_last_i) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          ac_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign ac_valid_o = ac_valid_q;
  assign ac_addr_o  = addr_q;
  assign ac_snoop_o = snoop_q;
  assign ac_prot_o  = prot_q;
  assign busy_o     = busy_q;
  assign owner_o    = owner_q;

endmodule

// File: tb/tb_snoop_port_arbiter.sv
// Randomized directed bench for snoop_port_arbiter against a transaction-level
// round-robin model.
module tb_snoop_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 64;

  logic                   clk = 1'b0;
  logic                   rst_i;
  logic [N-1:0]           req_ac_valid;
  logic [N-1:0]           req_ac_ready_o;
  logic [N-1:0][AW-1:0]   req_ac_addr;
  logic [N-1:0][3:0]      req_ac_snoop;
  logic [N-1:0][2:0]      req_ac_prot;
  logic [N-1:0]           req_cr_valid_o;
  logic [N-1:0]           req_cr_ready;
  logic [4:0]             req_cr_resp_o;
  logic [N-1:0]           req_cd_valid_o;
  logic [N-1:0]           req_cd_ready;
  logic [DW-1:0]          req_cd_data_o;
  logic                   req_cd_last_o;
  logic                   ac_valid_o;
  logic                   ac_ready_i;
  logic [AW-1:0]          ac_addr_o;
  logic [3:0]             ac_snoop_o;
  logic [2:0]             ac_prot_o;
  logic                   cr_valid_i;
  logic                   cr_ready_o;
  logic [4:0]             cr_resp_i;
  logic                   cd_valid_i;
  logic                   cd_ready_o;
  logic [DW-1:0]          cd_data_i;
  logic                   cd_last_i;
  logic                   busy_o;
  logic [0:0]             owner_o;

  int n_tests = 0;
  int n_fail  = 0;
  int last_m  = N - 1;  // model: most recently served source

  always #5 clk = ~clk;

  snoop_port_arbiter #(
    .NumReq   (N),
    .AddrWidth(AW),
    .DataWidth(DW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_ac_valid_i (req_ac_valid),
    .req_ac_ready_o (req_ac_ready_o),
    .req_ac_addr_i  (req_ac_addr),
    .req_ac_snoop_i (req_ac_snoop),
    .req_ac_prot_i  (req_ac_prot),
    .req_cr_valid_o (req_cr_valid_o),
    .req_cr_ready_i (req_cr_ready),
    .req_cr_resp_o  (req_cr_resp_o),
    .req_cd_valid_o (req_cd_valid_o),
    .req_cd_ready_i (req_cd_ready),
    .req_cd_data_o  (req_cd_data_o),
    .req_cd_last_o  (req_cd_last_o),
    .ac_valid_o     (ac_valid_o),
    .ac_ready_i     (ac_ready_i),
    .ac_addr_o      (ac_addr_o),
    .ac_snoop_o     (ac_snoop_o),
    .ac_prot_o      (ac_prot_o),
    .cr_valid_i     (cr_valid_i),
    .cr_ready_o     (cr_ready_o),
    .cr_resp_i      (cr_resp_i),
    .cd_valid_i     (cd_valid_i),
    .cd_ready_o     (cd_ready_o),
    .cd_data_i      (cd_data_i),
    .cd_last_i      (cd_last_i),
    .busy_o         (busy_o),
    .owner_o        (owner_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last_m + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] r;
    r = '0;
    r[w] = 1'b1;
    return r;
  endfunction

  task automatic randomize_sources();
    for (int s = 0; s < N; s++) begin
      req_ac_addr[s]  = {$urandom, $urandom};
      req_ac_snoop[s] = 4'($urandom);
      req_ac_prot[s]  = 3'($urandom);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ac_valid"}, 64'(ac_valid_o), 64'd0);
    chk({tag, "_ac_addr"},  64'(ac_addr_o), 64'd0);
    chk({tag, "_ac_snoop"}, 64'(ac_snoop_o), 64'd0);
    chk({tag, "_ac_prot"},  64'(ac_prot_o), 64'd0);
    chk({tag, "_busy"},     64'(busy_o), 64'd0);
    chk({tag, "_owner"},    64'(owner_o), 64'd0);
    chk({tag, "_cr_ready"}, 64'(cr_ready_o), 64'd0);
    chk({tag, "_cd_ready"}, 64'(cd_ready_o), 64'd0);
    chk({tag, "_cr_valid"}, 64'(req_cr_valid_o), 64'd0);
    chk({tag, "_cd_valid"}, 64'(req_cd_valid_o), 64'd0);
    chk({tag, "_cr_resp"},  64'(req_cr_resp_o), 64'd0);
    chk({tag, "_cd_data"},  64'(req_cd_data_o), 64'd0);
    chk({tag, "_cd_last"},  64'(req_cd_last_o), 64'd0);
  endtask

  // One snoop transaction starting in IDLE at posedge+1.  rst_beat >= 0 resets
  // the DUT after that many CD beats; next_valids is raised on the final CR edge.
  task automatic do_txn(input logic [N-1:0] valids, input int ac_wait, input int cr_wait,
                        input bit data, input int beats, input int rst_beat,
                        input logic [N-1:0] next_valids);
    int w;
    logic [AW-1:0] e_addr;
    logic [3:0]    e_snoop;
    logic [2:0]    e_prot;
    logic [4:0]    resp;
    logic [DW-1:0] d;
    randomize_sources();
    req_ac_valid = valids;
    #1;
    w = pick(valids);
    chk("idle_busy", 64'(busy_o), 64'd0);
    chk("grant", 64'(req_ac_ready_o), 64'(onehot(w)));
    e_addr  = req_ac_addr[w];
    e_snoop = req_ac_snoop[w];
    e_prot  = req_ac_prot[w];
    @(posedge clk); #1;
    last_m = w;
    req_ac_valid = '0;
    randomize_sources();
    #1;
    chk("ac_valid_c1", 64'(ac_valid_o), 64'd1);
    chk("ac_addr", ac_addr_o, e_addr);
    chk("ac_snoop", 64'(ac_snoop_o), 64'(e_snoop));
    chk("ac_prot", 64'(ac_prot_o), 64'(e_prot));
    chk("owner", 64'(owner_o), 64'(w));
    chk("busy", 64'(busy_o), 64'd1);
    chk("no_accept_ac", 64'(req_ac_ready_o), 64'd0);
    for (int c = 0; c < ac_wait; c++) begin
      req_ac_valid = N'($urandom);
      @(posedge clk); #1;
      chk("ac_hold_valid", 64'(ac_valid_o), 64'd1);
      chk("ac_hold_addr", ac_addr_o, e_addr);
      chk("ac_hold_noacc", 64'(req_ac_ready_o), 64'd0);
      req_ac_valid = '0;
    end
    ac_ready_i = 1'b1;
    @(posedge clk); #1;
    ac_ready_i = 1'b0;
    chk("ac_drop", 64'(ac_valid_o), 64'd0);
    resp = 5'($urandom);
    resp[0] = data;
    cr_valid_i = 1'b1;
    cr_resp_i  = resp;
    for (int c = 0; c < cr_wait; c++) begin
      req_cr_ready = N'($urandom);
      req_cr_ready[w] = 1'b0;
      #1;
      chk("cr_stall_valid", 64'(req_cr_valid_o), 64'(onehot(w)));
      chk("cr_stall_ready", 64'(cr_ready_o), 64'd0);
      chk("cr_resp", 64'(req_cr_resp_o), 64'(resp));
      @(posedge clk); #1;
      chk("cr_stall_busy", 64'(busy_o), 64'd1);
    end
    req_cr_ready = N'($urandom);
    req_cr_ready[w] = 1'b1;
    #1;
    chk("cr_valid", 64'(req_cr_valid_o), 64'(onehot(w)));
    chk("cr_ready", 64'(cr_ready_o), 64'd1);
    if (next_valids != '0) begin
      req_ac_valid = next_valids;
      #1;
      chk("late_no_accept", 64'(req_ac_ready_o), 64'd0);
    end
    @(posedge clk); #1;
    cr_valid_i = 1'b0;
    cr_resp_i = '0;
    req_cr_ready = '0;
    if (data) begin
      for (int b = 0; b < beats; b++) begin
        if (b == rst_beat) begin
          rst_i = 1'b1;
          @(posedge clk); #1;
          rst_i = 1'b0;
          cd_valid_i = 1'b0;
          cd_last_i = 1'b0;
          last_m = N - 1;
          #1;
          check_reset_outputs("rst_mid");
          return;
        end
        d = {$urandom, $urandom};
        cd_valid_i = 1'b1;
        cd_data_i  = d;
        cd_last_i  = (b == beats - 1);
        req_cd_ready = N'($urandom);
        req_cd_ready[w] = 1'b1;
        #1;
        chk("cd_valid", 64'(req_cd_valid_o), 64'(onehot(w)));
        chk("cd_ready", 64'(cd_ready_o), 64'd1);
        chk("cd_data", req_cd_data_o, d);
        chk("cd_last", 64'(req_cd_last_o), 64'(b == beats - 1));
        chk("cd_no_cr", 64'(req_cr_valid_o), 64'd0);
        @(posedge clk); #1;
      end
      cd_valid_i = 1'b0;
      cd_last_i = 1'b0;
      req_cd_ready = '0;
    end
    #1;
    chk("end_busy", 64'(busy_o), 64'd0);
    chk("end_cd_valid", 64'(req_cd_valid_o), 64'd0);
    chk("end_cd_ready", 64'(cd_ready_o), 64'd0);
    chk("end_cd_data", req_cd_data_o, 64'd0);
    chk("end_cr_ready", 64'(cr_ready_o), 64'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    req_ac_valid = '0;
    req_cr_ready = '0;
    req_cd_ready = '0;
    ac_ready_i = 1'b0;
    cr_valid_i = 1'b0;
    cr_resp_i = '0;
    cd_valid_i = 1'b0;
    cd_data_i = '0;
    cd_last_i = 1'b0;
    randomize_sources();
    repeat (2) @(posedge clk);
    #1;
    req_ac_valid = 2'b01;
    #1;
    chk("rst_ac_ready", 64'(req_ac_ready_o), 64'd0);
    req_ac_valid = '0;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_i = 1'b0;

    // single source, minimum latency without data
    do_txn(2'b01, 0, 0, 1'b0, 0, -1, '0);
    // src1 with 4 data beats
    do_txn(2'b10, 0, 0, 1'b1, 4, -1, '0);
    // round robin with both requesting
    for (int t = 0; t < 6; t++) do_txn(2'b11, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), $urandom_range(1, 3), -1, '0);
    // backpressure
    do_txn(2'b11, 5, 3, 1'b0, 0, -1, '0);
    // reset in CD after 2 of 4 beats, then src0 must win
    do_txn(2'b11, 0, 0, 1'b1, 4, 2, '0);
    do_txn(2'b11, 0, 0, 1'b0, 0, -1, '0);
    // late contention: src0 raises valid on the src1 CR handshake edge
    do_txn(2'b10, 0, 0, 1'b0, 0, -1, 2'b01);
    do_txn(2'b01, 0, 0, 1'b0, 0, -1, '0);
    // requester drops before being accepted
    @(posedge clk); #1;
    req_ac_valid = 2'b10;
    #1;
    chk("drop_ready_seen", 64'(req_ac_ready_o), 64'b10);
    req_ac_valid = '0;
    #1;
    chk("drop_ready_gone", 64'(req_ac_ready_o), 64'd0);
    @(posedge clk); #1;
    chk("drop_no_grant", 64'(busy_o), 64'd0);
    // random mix
    for (int t = 0; t < 20; t++) begin
      logic [N-1:0] v;
      v = N'($urandom_range(1, 3));
      do_txn(v, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), $urandom_range(1, 4), -1, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snoop_port_arbiter.md
# snoop_port_arbiter

Round-robin arbiter that shares one data cache's ACE snoop port (AC request, CR response, CD data channels) between `NumReq` snoop sources, e.g. several coherency-interconnect ports or a test snoop generator plus an interconnect.
- Serves one complete snoop transaction at a time: AC handshake, CR handshake, then every CD beat when data is transferred.
- Sits between the snoop sources and the `std_nbdcache` snoop interface.
- Routes CR/CD only to the source that owns the current transaction.

## Interface
Parameters:
- `NumReq`, 2, number of snoop sources (≥1).
- `AddrWidth`, 64, AC address width.
- `DataWidth`, 64, CD data width.
- `IdxWidth`, `(NumReq>1) ? $clog2(NumReq) : 1`, owner index width (derived).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk_i` in 1: clock.
  - `rst_i` in 1: synchronous active-high reset.
- Source side:
  - `req_ac_valid_i` in [NumReq]: per-source snoop request valid.
  - `req_ac_ready_o` out [NumReq]: per-source request accept.
  - `req_ac_addr_i` in [NumReq][AddrWidth]: snoop address.
  - `req_ac_snoop_i` in [NumReq][4]: ACSNOOP.
  - `req_ac_prot_i` in [NumReq][3]: ACPROT.
  - `req_cr_valid_o` out [NumReq]: CR valid to the owner only.
  - `req_cr_ready_i` in [NumReq]: per-source CR ready.
  - `req_cr_resp_o` out 5: CRRESP, broadcast.
  - `req_cd_valid_o` out [NumReq]: CD valid to the owner only.
  - `req_cd_ready_i` in [NumReq]: per-source CD ready.
  - `req_cd_data_o` out DataWidth: CD data, broadcast.
  - `req_cd_last_o` out 1: CD last, broadcast.
- Cache side:
  - `ac_valid_o` out 1: AC valid.
  - `ac_ready_i` in 1: AC ready.
  - `ac_addr_o` out AddrWidth: AC address.
  - `ac_snoop_o` out 4: ACSNOOP.
  - `ac_prot_o` out 3: ACPROT.
  - `cr_valid_i` in 1: CR valid.
  - `cr_ready_o` out 1: CR ready.
  - `cr_resp_i` in 5: CRRESP.
  - `cd_valid_i` in 1: CD valid.
  - `cd_ready_o` out 1: CD ready.
  - `cd_data_i` in DataWidth: CD data.
  - `cd_last_i` in 1: CD last.
- Status:
  - `busy_o` out 1: high in any state other than IDLE.
  - `owner_o` out IdxWidth: index of the current or last granted source.

## Operation
State machine: IDLE, AC, CR, CD.

- **IDLE**
  - Winner = first source with `req_ac_valid_i` set, searching cyclically from `last+1`.
  - `req_ac_ready_o[winner]`=1, driven combinationally; all other ready bits are 0.
  - On that handshake:
    - latch addr/snoop/prot into the request register;
    - `owner`←winner, `last`←winner;
    - go to AC.
- **AC**
  - `ac_valid_o`=1 and the AC fields come from the request register; they are held stable until `ac_ready_i`.
  - On `ac_ready_i`, go to CR.
  - No source is accepted outside IDLE.
- **CR**
  - Combinational pass-through:
    - `req_cr_valid_o[owner]`=`cr_valid_i`;
    - `cr_ready_o`=`req_cr_ready_i[owner]`;
    - `req_cr_resp_o`=`cr_resp_i`.
  - On `cr_valid_i & cr_ready_o`: if `cr_resp_i[0]` (DataTransfer) is set, go to CD; otherwise go to IDLE.
- **CD**
  - Combinational pass-through:
    - `req_cd_valid_o[owner]`=`cd_valid_i`;
    - `cd_ready_o`=`req_cd_ready_i[owner]`;
    - data and last are forwarded.
  - On a handshake with `cd_last_i`=1, go to IDLE.
  - The number of beats is unbounded and is counted by none.
- **Non-owner sources** see `req_cr_valid_o`/`req_cd_valid_o`=0 at all times.
- **Outside CR/CD**:
  - `cr_ready_o`=0 and `cd_ready_o`=0;
  - `req_cr_resp_o`, `req_cd_data_o` and `req_cd_last_o` are driven to 0.
- **Fairness**: a source that was just served has the lowest priority in the next arbitration. With all sources continuously requesting, grants cycle 0,1,…,NumReq-1,0.
- **NumReq=1**: source 0 always wins; `owner_o`=0.

## Timing
- **Reset** (synchronous, evaluated at the clock edge):
  - state←IDLE, `owner`←0, `last`←NumReq-1 (source 0 has first priority), request register←0.
  - Reset value of every output:
    - all valid/ready outputs 0 (the IDLE ready is 0 while `rst_i` is high);
    - `busy_o`=0, `owner_o`=0;
    - data, resp and address outputs 0.
- **Reset mid-transaction**: the transaction is dropped with no response to the source. The cycle after reset, all outputs are at reset values.
- **Latency**:
  - Accept edge at cycle 0 → `ac_valid_o`=1 in cycle 1.
  - Minimum snoop without data occupies 3 cycles; the next acceptance is possible in cycle 3.
  - With data: add 1 cycle per CD beat.
- **Simultaneous events**:
  - A new request arriving in the same cycle a transaction ends (the CR or last-CD handshake edge) is accepted no earlier than the following cycle, because acceptance only occurs in IDLE.
  - A requester dropping valid before being accepted is allowed and causes no grant.
- **Backpressure**: the AC fields must not change while `ac_valid_o`=1 and `ac_ready_i`=0. CR and CD stall for as long as either side stalls.

## Test plan
- **Single source, no data**: src0 requests addr 0x1000, snoop 0x0, cache answers with `cr_resp_i`=5'b00000.
  - `ac_valid_o` in cycle 1 with addr 0x1000.
  - `req_cr_valid_o[0]` is passed through; IDLE 3 cycles after acceptance; `busy_o` falls.
- **Data transfer**: src1 is snooped, CR resp 5'b00001, then 4 CD beats 0xA0..0xA3 with last on beat 4.
  - Only src1 sees `req_cd_valid_o`; data arrives in order; return to IDLE after beat 4.
- **Round-robin**: both sources hold valid continuously for 6 transactions.
  - Grant order 0,1,0,1,0,1; `owner_o` matches.
- **Backpressure**: `ac_ready_i` held low for 5 cycles, and `req_cr_ready_i[owner]` low for 3 cycles.
  - AC fields stay stable; `cr_ready_o`=0 while the source ready is low; no state change.
- **Reset mid-operation**: `rst_i` asserted in the CD state after 2 of 4 beats.
  - Next cycle: state IDLE; all valid/ready outputs 0; `owner_o`=0; src0 wins the next arbitration.
- **Late contention**: src0 requests on the same edge as the src1 CR handshake (resp 0).
  - src0 is accepted in the following cycle and reaches AC one cycle later.
